// File: rtl/restmul_recon.sv
// restmul_recon
//   Sequential shift-and-add reconstructor. It runs in the opposite direction
//   to the 5-by-3 restoring divider: given quotient Q, divisor D and remainder
//   R, it rebuilds the dividend X = Q*D + R. It also flags tuples that no legal
//   divide could have produced.
//
//   Processing order: one quotient bit per cycle, LSB first.
//   Latency: out_valid rises exactly QW clock edges after the accept edge.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only while idle
//   q_in, d_in, r_in    quotient, divisor and remainder, sampled on accept
//   out_valid/out_ready output handshake; the result is held until taken
//   x_out               exact Q*D+R; never truncated
//   ovf                 x_out >= 2^XW, so it is not a legal XW-bit dividend
//   rem_err             r_in >= d_in, which includes d_in == 0

module restmul_recon #(
    parameter int QW = 3,
    parameter int DW = 3,
    parameter int XW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    q_in,
    input  logic [DW-1:0]    d_in,
    input  logic [DW-1:0]    r_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW+DW-1:0] x_out,
    output logic             ovf,
    output logic             rem_err
);

    // The largest possible result is (2^DW-1)*2^QW, which still fits in
    // QW+DW bits. The accumulator therefore never wraps.
    localparam int AW = QW + DW;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  acc, mcand, acc_nxt;
    logic [QW-1:0]  mplier;
    logic [CW-1:0]  cnt;
    logic           rem_err_pend;
    logic           accept, last, retire;
    logic           ovf_nxt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                accept    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == CW'(QW - 1)) begin
                last      = 1'b1;
                state_nxt = DONE;
            end
            DONE: if (out_ready) begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // acc_nxt is the partial product after the current quotient bit is added.
    // On the last RUN edge it is the final result.
    assign acc_nxt = acc + (mplier[cnt] ? (mcand << cnt) : '0);
    assign ovf_nxt = |(acc_nxt >> XW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            rem_err_pend <= 1'b0;
            x_out        <= '0;
            ovf          <= 1'b0;
            rem_err      <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (accept) begin
                // The remainder seeds the accumulator, so only Q*D remains
                // to be added.
                acc          <= AW'(r_in);
                mcand        <= AW'(d_in);
                mplier       <= q_in;
                cnt          <= '0;
                rem_err_pend <= (r_in >= d_in);
            end else if (state == RUN) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
            end

            // The visible flags move only when a new result is published.
            // This lets the previous result outlive the next accept.
            if (last) begin
                x_out     <= acc_nxt;
                ovf       <= ovf_nxt;
                rem_err   <= rem_err_pend;
                out_valid <= 1'b1;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restmul_recon.sv
// Testbench for restmul_recon. It drives directed tuples, backpressure and
// asynchronous reset scenarios, then an exhaustive sweep with random stalls.
// Expected values come from plain arithmetic on Q, D and R.
module tb_restmul_recon;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] q_in = '0, d_in = '0, r_in = '0;
    logic       in_ready, out_valid, ovf, rem_err;
    logic [5:0] x_out;

    int errs = 0;
    int checks = 0;

    restmul_recon #(.QW(3), .DW(3), .XW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q_in     (q_in),
        .d_in     (d_in),
        .r_in     (r_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .ovf      (ovf),
        .rem_err  (rem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Runs one transaction. The result is held for `stall` cycles before it
    // is taken. If `pulse` is set, an in_valid pulse is injected while the
    // result is held.
    task automatic txn(input int q, input int d, input int r, input int stall, input bit pulse);
        int x, lat;
        bit xo, xr;
        x  = q * d + r;
        xo = (x >= 32);
        xr = (r >= d);
        @(negedge clk);
        chk("in_ready_idle", int'(in_ready), 1);
        q_in = 3'(q); d_in = 3'(d); r_in = 3'(r); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble the operands: only the values sampled at accept may count.
        q_in = 3'($urandom); d_in = 3'($urandom); r_in = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 3);
        chk("x_out", int'(x_out), x);
        chk("ovf", int'(ovf), int'(xo));
        chk("rem_err", int'(rem_err), int'(xr));
        for (int i = 0; i < stall; i++) begin
            chk("in_ready_busy", int'(in_ready), 0);
            in_valid = (pulse && i == 1);
            if (in_valid) begin
                q_in = 3'd6; d_in = 3'd1; r_in = 3'd0;
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_x", int'(x_out), x);
            chk("hold_ovf", int'(ovf), int'(xo));
            chk("hold_rem_err", int'(rem_err), int'(xr));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("retire_valid", int'(out_valid), 0);
        chk("retire_in_ready", int'(in_ready), 1);
        chk("retire_x_kept", int'(x_out), x);
        if (pulse) begin
            // The ignored pulse must not show up as an extra transaction.
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk("no_ghost", int'(out_valid), 0);
            end
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_rem_err", int'(rem_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        txn(3, 5, 2, 0, 0);   // 17
        txn(7, 7, 6, 0, 0);   // 55, ovf
        txn(7, 4, 3, 0, 0);   // 31, boundary without ovf
        txn(5, 0, 3, 0, 0);   // 3, rem_err from a zero divisor
        txn(2, 3, 3, 0, 0);   // 9, rem_err
        txn(6, 5, 1, 5, 1);   // backpressure with an ignored pulse

        // Asynchronous reset one edge into RUN
        txn(7, 5, 6, 0, 0);   // leaves x_out=41, ovf=1, rem_err=1 visible
        @(negedge clk);
        q_in = 3'd3; d_in = 3'd5; r_in = 3'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_x_out", int'(x_out), 0);
        chk("async_ovf", int'(ovf), 0);
        chk("async_rem_err", int'(rem_err), 0);
        chk("async_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        txn(1, 4, 3, 0, 0);   // 7

        // Exhaustive sweep with random stalls
        for (int q = 0; q < 8; q++)
            for (int d = 0; d < 8; d++)
                for (int r = 0; r < 8; r++)
                    txn(q, d, r, int'($urandom_range(0, 3)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
